// File: rtl/sine_seq_pkg.sv
// -----------------------------------------------------------------------------
// sine_seq_pkg
// Shared types and constants for the sine LUT sequencer.
//   seq_state_t  : sequencer state encoding (IDLE, RUN, DRAIN)
//   QUAD_DIV     : a quarter period of the LUT is LUT_SIZE / QUAD_DIV entries
//   quad_offset  : index offset that turns a sine index into a cosine index
// -----------------------------------------------------------------------------
package sine_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int QUAD_DIV = 4;

    function automatic int quad_offset(input int lut_size);
        return lut_size / QUAD_DIV;
    endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// -----------------------------------------------------------------------------
// sine_phase_acc
// Phase accumulator for the sine sequencer. Holds the phase register, adds the
// step on every issued sample (wrapping mod 2^PHASE_WIDTH) and exposes the top
// SEL_WIDTH bits as the LUT index.
// Ports:
//   clk       in   clock, posedge
//   rst       in   asynchronous active-low reset
//   load      in   load phase from load_val (start of a run)
//   load_val  in   start phase
//   adv       in   advance phase by step
//   step      in   phase increment
//   index     out  phase[PHASE_WIDTH-1 -: SEL_WIDTH]
// -----------------------------------------------------------------------------
module sine_phase_acc #(
    parameter int PHASE_WIDTH = 16,
    parameter int SEL_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [PHASE_WIDTH-1:0] load_val,
    input  logic                   adv,
    input  logic [PHASE_WIDTH-1:0] step,
    output logic [SEL_WIDTH-1:0]   index
);

    logic [PHASE_WIDTH-1:0] phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (load) begin
            phase <= load_val;
        end else if (adv) begin
            phase <= phase + step;
        end
    end

    assign index = phase[PHASE_WIDTH-1 -: SEL_WIDTH];

endmodule

// File: rtl/sine_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sine_seq_ctrl
// Sequencer for a sine lookup table with one cycle of registered latency.
// Runs a phase accumulator, drives the LUT index and flags with out_valid the
// cycles in which the LUT output holds a valid sample. Supports bursts of
// cfg_count samples or continuous runs (cfg_count == 0). Configuration is
// accepted only while idle.
//
// Optional build macro SINE_SEQ_COS_EN adds lut_index_cos, a quarter-period
// shifted copy of lut_index for a second (cosine) LUT instance.
//
// Ports:
//   clk            in   clock, posedge
//   rst            in   asynchronous active-low reset
//   cfg_valid      in   config write request
//   cfg_ready      out  high only in IDLE
//   cfg_step       in   phase increment per sample
//   cfg_phase0     in   start phase
//   cfg_count      in   samples per burst, 0 = continuous
//   start          in   pulse, begins a run from IDLE
//   stop           in   pulse, ends a run early
//   lut_index      out  LUT index
//   out_valid      out  LUT output is a valid sample this cycle
//   out_ready      in   consumer accepts the sample
//   busy           out  not IDLE
//   done           out  one-cycle pulse when a run finishes
//   lut_index_cos  out  (SINE_SEQ_COS_EN only) lut_index + LUT_SIZE/4
//
// state | meaning
// IDLE  | waiting for start, config writes accepted
// RUN   | issuing samples whenever the output slot is free or being consumed
// DRAIN | no new issues, waiting for the last shown sample to be accepted
// -----------------------------------------------------------------------------
module sine_seq_ctrl
    import sine_seq_pkg::*;
#(
    parameter int LUT_SIZE    = 32,
    parameter int SEL_WIDTH   = $clog2(LUT_SIZE),
    parameter int PHASE_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [PHASE_WIDTH-1:0] cfg_phase0,
    input  logic [CNT_WIDTH-1:0]   cfg_count,
    input  logic                   start,
    input  logic                   stop,
    output logic [SEL_WIDTH-1:0]   lut_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
`ifdef SINE_SEQ_COS_EN
    ,
    output logic [SEL_WIDTH-1:0]   lut_index_cos
`endif
);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [PHASE_WIDTH-1:0] step_q;
    logic [PHASE_WIDTH-1:0] phase0_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [SEL_WIDTH-1:0]   shown_idx;
    logic [SEL_WIDTH-1:0]   phase_idx;

    logic adv;
    logic issue;
    logic last_issue;
    logic drain_exit;
    logic start_go;

    sine_phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .SEL_WIDTH   (SEL_WIDTH)
    ) u_phase_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (start_go),
        .load_val (phase0_q),
        .adv      (issue),
        .step     (step_q),
        .index    (phase_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go)              state_nxt = RUN;
            RUN:     if (stop || last_issue)    state_nxt = DRAIN;
            DRAIN:   if (drain_exit)            state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Output / control decode. Stop beats an issue in the same cycle so a
    // stopped run never emits one extra sample.
    always_comb begin
        cfg_ready  = (state == IDLE);
        busy       = (state != IDLE);
        start_go   = (state == IDLE) && start;
        adv        = (state == RUN) && (!out_valid || out_ready);
        issue      = adv && !stop;
        last_issue = issue && (count_q != '0) && (remaining == CNT_WIDTH'(1));
        drain_exit = (state == DRAIN) && (!out_valid || out_ready);
    end

    // While a sample is stalled the LUT must keep re-reading the same entry,
    // because its output register reloads every cycle.
    assign lut_index = (out_valid && !out_ready) ? shown_idx : phase_idx;

`ifdef SINE_SEQ_COS_EN
    // Power-of-two LUT: natural wrap of the SEL_WIDTH sum is the modulo.
    assign lut_index_cos = lut_index + SEL_WIDTH'(quad_offset(LUT_SIZE));
`endif

    // Configuration, burst counter and output handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q    <= '0;
            phase0_q  <= '0;
            count_q   <= '0;
            remaining <= '0;
            shown_idx <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                step_q   <= cfg_step;
                phase0_q <= cfg_phase0;
                count_q  <= cfg_count;
            end

            if (start_go) begin
                remaining <= count_q;
            end else if (issue && (count_q != '0)) begin
                remaining <= remaining - CNT_WIDTH'(1);
            end

            if (issue) begin
                shown_idx <= lut_index;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            done <= drain_exit;
        end
    end

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sine_seq_ctrl
// Self-checking bench for sine_seq_ctrl with a registered 32-entry sine LUT
// (amplitude 32767). Expected samples come from the phase rule
// sample k = sin_lut(((phase0 + k*step) mod 2^16) / 2^11).
// -----------------------------------------------------------------------------
module tb_sine_seq_ctrl;

    localparam int LUT_SIZE    = 32;
    localparam int SEL_WIDTH   = 5;
    localparam int PHASE_WIDTH = 16;
    localparam int CNT_WIDTH   = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [PHASE_WIDTH-1:0] cfg_step = '0;
    logic [PHASE_WIDTH-1:0] cfg_phase0 = '0;
    logic [CNT_WIDTH-1:0]   cfg_count = '0;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic [SEL_WIDTH-1:0]   lut_index;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   busy;
    logic                   done;
`ifdef SINE_SEQ_COS_EN
    logic [SEL_WIDTH-1:0]   lut_index_cos;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    sine_seq_ctrl #(
        .LUT_SIZE    (LUT_SIZE),
        .SEL_WIDTH   (SEL_WIDTH),
        .PHASE_WIDTH (PHASE_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_step   (cfg_step),
        .cfg_phase0 (cfg_phase0),
        .cfg_count  (cfg_count),
        .start      (start),
        .stop       (stop),
        .lut_index  (lut_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef SINE_SEQ_COS_EN
        ,
        .lut_index_cos (lut_index_cos)
`endif
    );

    function automatic logic signed [15:0] sine_val(input int idx);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * idx / 32.0);
        if (r >= 0.0) r = r + 0.5;
        else          r = r - 0.5;
        return 16'($rtoi(r));
    endfunction

    function automatic logic signed [15:0] exp_sample(input int unsigned p0, input int unsigned st,
                                                      input int k);
        int unsigned p;
        p = (p0 + st * k) % 65536;
        return sine_val(int'(p / 2048));
    endfunction

    // Downstream LUT: one registered read per cycle
    logic signed [15:0] lut_q;
    always @(posedge clk) lut_q <= sine_val(int'(lut_index));
`ifdef SINE_SEQ_COS_EN
    logic signed [15:0] lut_cos_q;
    always @(posedge clk) lut_cos_q <= sine_val(int'(lut_index_cos));
`endif

    // Monitor: record accepted samples and done pulses
    logic signed [15:0] cap_q[$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) cap_q.push_back(lut_q);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic configure(input int unsigned st, input int unsigned p0, input int unsigned cnt);
        cfg_valid  = 1'b1;
        cfg_step   = PHASE_WIDTH'(st);
        cfg_phase0 = PHASE_WIDTH'(p0);
        cfg_count  = CNT_WIDTH'(cnt);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < budget) begin
            tick();
            if (done_cnt > base) ok = 1'b1;
            i++;
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        n_cmp++; if (lut_index !== 5'd0) begin n_err++; $display("FAIL reset_lut_index got %0d want 0", lut_index); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_burst();
        int b, d;
        bit ok;
        logic signed [15:0] tbl [4];
        tbl = '{16'sd0, 16'sd6393, 16'sd12539, 16'sd18204};
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(2048, 0, 4);
        b = cap_q.size(); d = done_cnt;
        pulse_start();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_err++; $display("FAIL burst_after_start valid=%b busy=%b cfg_ready=%b want 0 1 0", out_valid, busy, cfg_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL burst_first_valid got %b want 1", out_valid); end
        wait_done(50, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_done_timeout got none want done"); end
        n_cmp++; if (cap_q.size() - b != 4) begin n_err++; $display("FAIL burst_beats got %0d want 4", cap_q.size() - b); end
        for (int k = 0; k < 4 && b + k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[b+k] !== tbl[k]) begin n_err++; $display("FAIL burst_sample%0d got %0d want %0d", k, cap_q[b+k], tbl[k]); end
        end
        repeat (3) tick();
        n_cmp++; if (done_cnt - d != 1) begin n_err++; $display("FAIL burst_done_count got %0d want 1", done_cnt - d); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_end got %b want 0", busy); end
    endtask

    task automatic test_continuous();
        int b, d, n_before, i;
        bit ok, shown;
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(4096, 0, 0);
        b = cap_q.size(); d = done_cnt;
        pulse_start();
        i = 0;
        while (cap_q.size() - b < 20 && i < 100) begin tick(); i++; end
        n_cmp++; if (cap_q.size() - b < 20) begin n_err++; $display("FAIL cont_20_beats got %0d want 20", cap_q.size() - b); end
        n_before = cap_q.size();
        shown = out_valid;
        pulse_stop();
        wait_done(20, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cont_done_timeout got none want done"); end
        n_cmp++; if (cap_q.size() != n_before + int'(shown)) begin
            n_err++; $display("FAIL cont_shown_delivered got %0d want %0d", cap_q.size(), n_before + int'(shown)); end
        for (int k = 0; b + k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[b+k] !== exp_sample(0, 4096, k)) begin
                n_err++; $display("FAIL cont_sample%0d got %0d want %0d", k, cap_q[b+k], exp_sample(0, 4096, k)); end
        end
        n_cmp++; if (done_cnt - d != 1) begin n_err++; $display("FAIL cont_done_count got %0d want 1", done_cnt - d); end
    endtask

    task automatic test_backpressure();
        int b, d, i;
        bit ok, found;
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(2048, 0, 8);
        b = cap_q.size(); d = done_cnt;
        pulse_start();
        found = 1'b0; i = 0;
        while (!found && i < 30) begin
            if (out_valid === 1'b1 && lut_q === 16'sd23170) found = 1'b1;
            else begin tick(); i++; end
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL bp_find_23170 got none want 23170 shown"); end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || lut_q !== 16'sd23170) begin
                n_err++; $display("FAIL bp_stall%0d valid=%b sample=%0d want 1 23170", c, out_valid, lut_q); end
        end
        out_ready = 1'b1;
        rand_rdy = 1'b1;
        wait_done(200, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_done_timeout got none want done"); end
        n_cmp++; if (cap_q.size() - b != 8) begin n_err++; $display("FAIL bp_beats got %0d want 8", cap_q.size() - b); end
        for (int k = 0; k < 8 && b + k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[b+k] !== exp_sample(0, 2048, k)) begin
                n_err++; $display("FAIL bp_sample%0d got %0d want %0d", k, cap_q[b+k], exp_sample(0, 2048, k)); end
        end
        if (cap_q.size() - b > 5) begin
            n_cmp++; if (cap_q[b+5] !== 16'sd27245) begin n_err++; $display("FAIL bp_next_after_stall got %0d want 27245", cap_q[b+5]); end
        end
    endtask

    task automatic test_cfg_busy();
        int b, d;
        int unsigned p0;
        bit ok;
        p0 = $urandom_range(0, 65535);
        rand_rdy = 1'b1;
        configure(2048, p0, 5);
        d = done_cnt;
        pulse_start();
        tick();
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL cfgbusy_ready got %b want 0", cfg_ready); end
        cfg_valid = 1'b1; cfg_step = 16'd9999; cfg_phase0 = 16'd123; cfg_count = 16'd1;
        tick(); tick();
        cfg_valid = 1'b0;
        wait_done(200, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cfgbusy_done1_timeout got none want done"); end
        b = cap_q.size(); d = done_cnt;
        rand_rdy = 1'b1;
        pulse_start();
        wait_done(200, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cfgbusy_done2_timeout got none want done"); end
        n_cmp++; if (cap_q.size() - b != 5) begin n_err++; $display("FAIL cfgbusy_beats got %0d want 5", cap_q.size() - b); end
        for (int k = 0; k < 5 && b + k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[b+k] !== exp_sample(p0, 2048, k)) begin
                n_err++; $display("FAIL cfgbusy_sample%0d got %0d want %0d", k, cap_q[b+k], exp_sample(p0, 2048, k)); end
        end
    endtask

    task automatic test_reset_mid();
        int b, d;
        int unsigned p0;
        bit ok;
        p0 = $urandom_range(0, 65535);
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(2048, p0, 10);
        d = done_cnt;
        pulse_start();
        repeat (4) tick();
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done); end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (done_cnt != d) begin n_err++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d); end
        configure(2048, p0, 10);
        b = cap_q.size(); d = done_cnt;
        pulse_start();
        wait_done(60, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_done_timeout got none want done"); end
        n_cmp++; if (cap_q.size() - b != 10) begin n_err++; $display("FAIL rstmid_beats got %0d want 10", cap_q.size() - b); end
        for (int k = 0; k < 10 && b + k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[b+k] !== exp_sample(p0, 2048, k)) begin
                n_err++; $display("FAIL rstmid_sample%0d got %0d want %0d", k, cap_q[b+k], exp_sample(p0, 2048, k)); end
        end
    endtask

    task automatic test_start_stop_idle();
        int b, d;
        bit ok;
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(3000, 500, 3);
        b = cap_q.size(); d = done_cnt;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL startstop_busy got %b want 1", busy); end
        wait_done(40, d, ok);
        n_cmp++; if (!ok || cap_q.size() - b != 3) begin
            n_err++; $display("FAIL startstop_beats got %0d want 3", cap_q.size() - b); end
    endtask

    task automatic test_stop_stalled();
        int b, d, n;
        bit ok;
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(2048, 0, 0);
        b = cap_q.size(); d = done_cnt;
        pulse_start();
        repeat (3) tick();
        out_ready = 1'b0;
        tick();
        n = cap_q.size();
        pulse_stop();
        tick();
        n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL stopstall_hold valid=%b busy=%b want 1 1", out_valid, busy); end
        out_ready = 1'b1;
        wait_done(20, d, ok);
        n_cmp++; if (!ok || cap_q.size() != n + 1) begin
            n_err++; $display("FAIL stopstall_delivered got %0d want %0d", cap_q.size(), n + 1); end
        for (int k = 0; b + k < cap_q.size(); k++) begin
            n_cmp++; if (cap_q[b+k] !== exp_sample(0, 2048, k)) begin
                n_err++; $display("FAIL stopstall_sample%0d got %0d want %0d", k, cap_q[b+k], exp_sample(0, 2048, k)); end
        end
    endtask

    task automatic test_random();
        int b, d;
        int unsigned st, p0, cnt;
        bit ok;
        for (int it = 0; it < 5; it++) begin
            st  = (it == 0) ? 0 : $urandom_range(1, 65535);
            p0  = $urandom_range(0, 65535);
            cnt = $urandom_range(1, 12);
            rand_rdy = 1'b0; out_ready = 1'b1;
            configure(st, p0, cnt);
            b = cap_q.size(); d = done_cnt;
            rand_rdy = 1'b1;
            pulse_start();
            wait_done(300, d, ok);
            n_cmp++; if (!ok || cap_q.size() - b != int'(cnt)) begin
                n_err++; $display("FAIL rand%0d_beats got %0d want %0d", it, cap_q.size() - b, cnt); end
            for (int k = 0; k < int'(cnt) && b + k < cap_q.size(); k++) begin
                n_cmp++; if (cap_q[b+k] !== exp_sample(p0, st, k)) begin
                    n_err++; $display("FAIL rand%0d_sample%0d got %0d want %0d", it, k, cap_q[b+k], exp_sample(p0, st, k)); end
            end
        end
    endtask

`ifdef SINE_SEQ_COS_EN
    task automatic test_cos();
        int d;
        bit ok;
        rand_rdy = 1'b0; out_ready = 1'b1;
        configure(2048, 0, 6);
        d = done_cnt;
        pulse_start();
        tick();
        n_cmp++; if (out_valid !== 1'b1 || lut_cos_q !== 16'sd32767) begin
            n_err++; $display("FAIL cos_first valid=%b sample=%0d want 1 32767", out_valid, lut_cos_q); end
        for (int c = 0; c < 6; c++) begin
            n_cmp++; if (int'(lut_index_cos) != (int'(lut_index) + 8) % 32) begin
                n_err++; $display("FAIL cos_index%0d got %0d want %0d", c, lut_index_cos, (int'(lut_index) + 8) % 32); end
            tick();
        end
        wait_done(40, d, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cos_done_timeout got none want done"); end
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_continuous();
        test_backpressure();
        test_cfg_busy();
        test_reset_mid();
        test_start_stop_idle();
        test_stop_stalled();
        test_random();
`ifdef SINE_SEQ_COS_EN
        test_cos();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sine_seq_ctrl.md
Name: sine_seq_ctrl

Overview:
Sequencer for the sine lookup table. It runs a phase accumulator and drives the LUT index port. It tracks the LUT's 1-cycle registered latency with an `out_valid`/`out_ready` handshake. It supports bursts of N samples or continuous runs, and configuration is accepted only while idle.

Parameters:
- LUT_SIZE, 32, entries in the downstream LUT; power of two.
- SEL_WIDTH, $clog2(LUT_SIZE), LUT index width.
- PHASE_WIDTH, 16, accumulator width; must be >= SEL_WIDTH.
- CNT_WIDTH, 16, burst counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  high only in IDLE.
- cfg_step  in  PHASE_WIDTH  phase increment per accepted sample.
- cfg_phase0  in  PHASE_WIDTH  start phase.
- cfg_count  in  CNT_WIDTH  samples per burst; 0 = continuous.
- start  in  1  single-cycle pulse; begins run from IDLE.
- stop  in  1  single-cycle pulse; ends continuous or burst run early.
- lut_index  out  SEL_WIDTH  to LUT index port.
- out_valid  out  1  LUT output this cycle is a valid sample.
- out_ready  in  1  consumer accepts sample.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse when a run finishes.

Behaviour:
- Reset values (async):
  - state = IDLE; phase = 0; step = 0; count = 0; remaining = 0.
  - shown_idx = 0; out_valid = 0; done = 0.
  - cfg_ready = 1 after reset (combinational from IDLE).
- Config: when cfg_valid && cfg_ready, latch step, phase0 and count at the clock edge. If cfg_valid is high outside IDLE, it is ignored with no side effects.
- Issue enable: adv = (state == RUN) && (!out_valid || out_ready).
- Index mux (combinational):
  - When out_valid && !out_ready, lut_index = shown_idx, so the LUT re-reads the sample being shown.
  - Otherwise lut_index = phase[PHASE_WIDTH-1 -: SEL_WIDTH].
- On adv:
  - shown_idx <= current index.
  - phase <= phase + step, wrapping mod 2^PHASE_WIDTH.
  - out_valid <= 1 at the next cycle, aligned with the LUT output of that index.
  - remaining decrements, unless count == 0.
- If out_valid && out_ready && !adv, then out_valid <= 0.
- Latency: start accepted at edge E → first sample valid at E+2. The extra cycle is the index issue from the freshly loaded phase.
- FSM states:
  - IDLE: on start, phase <= phase0 and remaining <= count → RUN.
  - RUN: issue while adv. Go to DRAIN when either:
    - the last burst sample is issued (remaining == 1 on adv, count != 0), or
    - stop is seen.
  - DRAIN: no new issues. Hold until out_valid is 0 or the held sample is accepted, then pulse done → IDLE.
- start while not IDLE is ignored. start and stop in the same cycle in IDLE: start wins and stop is ignored.
- Stop in RUN takes priority over an issue in the same cycle, so no new sample is issued. A sample already shown is still delivered.
- Backpressure: the shown sample is held stable for any number of stall cycles, and the phase does not advance.
- cfg_step = 0 is legal (constant output).
- Reset mid-run: out_valid drops immediately and no done pulse is generated.

Optional Feature:
- Macro: SINE_SEQ_COS_EN.
- With the macro defined:
  - Adds output lut_index_cos [SEL_WIDTH-1:0] = lut_index + LUT_SIZE/4, mod LUT_SIZE.
  - The same stall mux applies, so a second LUT instance gives a quadrature cosine aligned with out_valid.
- Without the macro: the port and its logic are absent.

Decomposition:
- Package sine_seq_pkg holds the state enum typedef (IDLE, RUN, DRAIN) and a localparam for the quadrant offset function.
- Sub-module sine_phase_acc (phase register, step add, index slice) is natural; the FSM and handshake stay in the top.

Test Plan:
Bench uses LUT_SIZE=32, PHASE_WIDTH=16 and a downstream sine_lut.
1. cfg step=2048, phase0=0, count=4; start; out_ready=1 → exactly 4 valid beats 0, 6393, 12539, 18204; then done pulses once; busy falls.
2. step=4096, count=0; start; run 20 beats; stop → values step by 2 indices (0, 12539, 23170, 30273, 32767, ...) and wrap past index 31; the sample already shown is still delivered, then done.
3. step=2048, count=8; drop out_ready for 3 cycles while sample 23170 is shown → out_valid and 23170 stay stable all 3 cycles; the next accepted value is 27245; no sample skipped or duplicated.
4. cfg_valid while busy with step=9999 → ignored; the next run uses the previous step.
5. Assert rst mid-burst → out_valid=0, busy=0 and done=0 immediately; the next start replays from phase0.
6. With SINE_SEQ_COS_EN: step=2048 → lut_index_cos = lut_index + 8; the first cos sample is 32767.
